wb_gpio_irq: RTL
================

# wb_gpio_irq

Parametrised 32-bit Wishbone GPIO controller with per-pin interrupts, the next generation of the fixed 8-bit GPIO slave. It connects directly to the 32-bit Wishbone interconnect, so no `wb_data_resize` bridge is needed. It adds:
- pin width of 1..32;
- input synchronisation;
- atomic set/clear of outputs;
- per-pin edge/level interrupts with sticky status, driving one line into `or1200_pic_ints`.

## Interface
- WIDTH, 32 — number of pins, 1..32; register bits ≥ WIDTH read 0 and ignore writes.
- SYNC_STAGES, 2 — input synchroniser depth, ≥2.
- RESET_OUT, 0 — reset value of DATA_OUT.
- RESET_DIR, 0 — reset value of DIR (1 = output).
- wb_clk  in  1  — single clock.
- wb_rst_n  in  1  — reset, synchronous, active-low.
- wb_adr_i  in  4  — word address (byte address bits 5:2).
- wb_dat_i  in  32  — write data.
- wb_sel_i  in  4  — byte enables, honoured on all writes.
- wb_we_i, wb_cyc_i, wb_stb_i  in  1 each — classic Wishbone handshake.
- wb_cti_i  in  3 — burst hint, ignored.
- wb_bte_i  in  2 — burst hint, ignored.
- wb_dat_o  out  32  — read data, registered.
- wb_ack_o  out  1  — transfer acknowledge.
- wb_err_o  out  1  — error acknowledge (unmapped address).
- wb_rty_o  out  1  — tied 0.
- gpio_i  in  WIDTH  — asynchronous pin inputs.
- gpio_o  out  WIDTH  — DATA_OUT; driven regardless of direction.
- gpio_dir_o  out  WIDTH  — DIR, for external tristate.
- irq_o  out  1  — registered interrupt request, level.

## Operation
Register map (word offset):
- 0 IN: read-only, synchronised pins.
- 1 OUT: read/write.
- 2 SET: write-1-set into OUT, reads 0.
- 3 CLR: write-1-clear in OUT, reads 0.
- 4 DIR: read/write.
- 5 IE: read/write.
- 6 TYPE: read/write; 0 = level, 1 = edge.
- 7 POL: read/write; level: 1 = high; edge: 1 = rising, 0 = falling.
- 8 STATUS: read, write-1-clear.

Address decode:
- Offsets 9–15: `wb_err_o` instead of ack; reads return 0; no state change.
- Byte lanes with `wb_sel_i = 0` leave the corresponding bits unchanged, including for SET/CLR/STATUS.

Interrupt status:
- A STATUS bit is set by its event independent of IE, so software can poll.
- Edge mode: set on the cycle the synchronised value differs from its previous-cycle copy in the POL direction.
- Level mode: set every cycle the synchronised level equals POL. A W1C therefore re-sets the bit on the next cycle while the level persists.
- Set and W1C on the same bit in the same cycle: set wins.
- Changing TYPE or POL does not clear STATUS.

`irq_o` is the registered value of `|(STATUS & IE)`.

Post-reset edge suppression: edge detection is masked until a counter reaches SYNC_STAGES+1 cycles after reset release. This prevents false edges while the synchroniser fills.

## Timing
- Reset (`wb_rst_n` low at a clock edge) sets:
  - OUT = RESET_OUT, DIR = RESET_DIR;
  - IE, TYPE, POL, STATUS = 0; synchroniser and previous-value flops = 0;
  - `wb_ack_o`, `wb_err_o`, `irq_o`, `wb_dat_o` = 0; suppression counter = 0.
- Reset mid-transfer drops ack/err immediately. No write takes effect in a reset cycle.
- Handshake:
  - `ack = cyc & stb & ~ack & ~err`, registered, so ack is one cycle after strobe.
  - The master holding `stb` gets ack every other cycle.
  - Writes update registers on the ack edge.
  - Read data is valid in the ack cycle.
  - Bursts are served as repeated classic cycles.
- Input latency: a pin change sampled at edge k appears in IN at edge k+SYNC_STAGES.
- Interrupt latency:
  - An edge status bit sets at edge k+SYNC_STAGES+1.
  - `irq_o` rises one cycle after the STATUS bit sets.
- W1C of STATUS deasserts `irq_o` one cycle after the ack edge, unless another event sets the bit.
- SET/CLR take effect on `gpio_o` at the ack edge. A write to OUT is the same.

## Structure
- Package/header `wb_gpio_irq_pkg`:
  - register offset constants, 4-bit;
  - TYPE/POL encodings;
  - the number of mapped registers (9).
- Sub-module `gpio_in_sync` (parameter SYNC_STAGES):
  - per-bit flop chain plus previous-value flop;
  - outputs `sync` and `prev`, instantiated WIDTH-wide.
- The top holds the register file, decoder, status logic, suppression counter and irq register.

## Test plan
- Reset values: after reset with RESET_OUT=0xA5, RESET_DIR=0x0F, WIDTH=8 → OUT reads 0xA5, DIR reads 0x0F, STATUS reads 0, `irq_o` = 0, `gpio_o` = 0xA5.
- Atomic output: write OUT=0x00, SET=0x81, CLR=0x01 → OUT reads 0x80. A SET write with `wb_sel_i`=4'b0010 and data 0xFFFF leaves bits 7:0 unchanged.
- Rising edge on pin 3: TYPE=0x08, POL=0x08, IE=0x08, then raise `gpio_i[3]` → STATUS=0x08 at +3 cycles, `irq_o` at +4. A W1C of 0x08 clears both, and a later falling edge does not re-set the bit.
- Level-high on pin 0 held: W1C of STATUS bit 0 → bit reads 1 again on the next read and `irq_o` stays high. Dropping the pin, then W1C, clears `irq_o`.
- Bus errors and width:
  - access to offset 12 → `wb_err_o` for one cycle, no ack, no state change;
  - WIDTH=5: write OUT=0xFFFFFFFF → reads 0x1F.
- Reset and suppression:
  - assert `wb_rst_n` low during a pending write → write is discarded;
  - `gpio_i` held high across reset with edge mode enabled → no STATUS set after release.

Source files
------------

// File: rtl/wb_gpio_irq_pkg.sv
// Shared constants and types for the Wishbone GPIO controller with per-pin interrupts.
package wb_gpio_irq_pkg;

    localparam int unsigned BUS_W    = 32;
    localparam int unsigned SEL_W    = BUS_W / 8;
    localparam int unsigned ADR_W    = 4;
    localparam int unsigned NUM_REGS = 9;

    localparam logic [ADR_W-1:0] OFS_IN     = 4'd0;
    localparam logic [ADR_W-1:0] OFS_OUT    = 4'd1;
    localparam logic [ADR_W-1:0] OFS_SET    = 4'd2;
    localparam logic [ADR_W-1:0] OFS_CLR    = 4'd3;
    localparam logic [ADR_W-1:0] OFS_DIR    = 4'd4;
    localparam logic [ADR_W-1:0] OFS_IE     = 4'd5;
    localparam logic [ADR_W-1:0] OFS_TYPE   = 4'd6;
    localparam logic [ADR_W-1:0] OFS_POL    = 4'd7;
    localparam logic [ADR_W-1:0] OFS_STATUS = 4'd8;

    localparam logic TYPE_LEVEL = 1'b0;
    localparam logic TYPE_EDGE  = 1'b1;
    localparam logic POL_LOW    = 1'b0;
    localparam logic POL_HIGH   = 1'b1;

    typedef struct packed {
        logic [ADR_W-1:0] adr;
        logic [BUS_W-1:0] dat;
        logic [SEL_W-1:0] sel;
        logic             we;
    } wb_req_t;

    // Expand byte enables into a per-bit write mask.
    function automatic logic [BUS_W-1:0] byte_mask(input logic [SEL_W-1:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/gpio_in_sync.sv
// Multi-flop input synchroniser with a previous-value copy for edge detection.
module gpio_in_sync #(
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] prev
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] stage;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage <= '0;
            prev  <= '0;
        end else begin
            stage <= {stage[SYNC_STAGES-2:0], din};
            prev  <= stage[SYNC_STAGES-1];
        end
    end

    assign sync = stage[SYNC_STAGES-1];

endmodule

// File: rtl/wb_gpio_irq.sv
// Wishbone GPIO slave: register file, decoder, sticky interrupt status and irq line.
module wb_gpio_irq
    import wb_gpio_irq_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [31:0] RESET_OUT   = '0,
    parameter logic [31:0] RESET_DIR   = '0
) (
    input  logic             wb_clk,
    input  logic             wb_rst_n,
    input  logic [ADR_W-1:0] wb_adr_i,
    input  logic [BUS_W-1:0] wb_dat_i,
    input  logic [SEL_W-1:0] wb_sel_i,
    input  logic             wb_we_i,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    input  logic [2:0]       wb_cti_i,
    input  logic [1:0]       wb_bte_i,
    output logic [BUS_W-1:0] wb_dat_o,
    output logic             wb_ack_o,
    output logic             wb_err_o,
    output logic             wb_rty_o,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_dir_o,
    output logic             irq_o
);

    localparam int unsigned CNT_W = $clog2(SYNC_STAGES + 2);

    wb_req_t          req;
    logic             access;
    logic             mapped;
    logic             wr_en;
    logic [BUS_W-1:0] bmask;
    logic [WIDTH-1:0] wmask;
    logic [WIDTH-1:0] wdat;
    logic [BUS_W-1:0] rdata;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] evt;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] out_r, dir_r, ie_r, type_r, pol_r, status_r;
    logic [CNT_W-1:0] supp_cnt;
    logic             supp_done;
    logic             unused_ok;

    assign req = '{adr: wb_adr_i, dat: wb_dat_i, sel: wb_sel_i, we: wb_we_i};

    gpio_in_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (wb_clk),
        .rst_n (wb_rst_n),
        .din   (gpio_i),
        .sync  (sync),
        .prev  (prev)
    );

    // Any new strobe not already being answered becomes one ack or err cycle.
    assign access = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
    assign mapped = req.adr < ADR_W'(NUM_REGS);
    assign wr_en  = access & mapped & req.we;
    assign bmask  = byte_mask(req.sel);
    assign wmask  = bmask[WIDTH-1:0];
    assign wdat   = req.dat[WIDTH-1:0] & wmask;
    assign w1c    = (wr_en && req.adr == OFS_STATUS) ? wdat : '0;

    assign supp_done = (supp_cnt == CNT_W'(SYNC_STAGES + 1));

    always_comb begin
        rdata = '0;
        case (req.adr)
            OFS_IN:     rdata = BUS_W'(sync);
            OFS_OUT:    rdata = BUS_W'(out_r);
            OFS_DIR:    rdata = BUS_W'(dir_r);
            OFS_IE:     rdata = BUS_W'(ie_r);
            OFS_TYPE:   rdata = BUS_W'(type_r);
            OFS_POL:    rdata = BUS_W'(pol_r);
            OFS_STATUS: rdata = BUS_W'(status_r);
            default:    rdata = '0;
        endcase
    end

    // Per-pin event; masked while the synchroniser refills after reset.
    always_comb begin
        evt = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            unique case ({type_r[i], pol_r[i]})
                {TYPE_LEVEL, POL_LOW}:  evt[i] = ~sync[i];
                {TYPE_LEVEL, POL_HIGH}: evt[i] = sync[i];
                {TYPE_EDGE,  POL_LOW}:  evt[i] = ~sync[i] & prev[i];
                {TYPE_EDGE,  POL_HIGH}: evt[i] = sync[i] & ~prev[i];
                default:                evt[i] = 1'b0;
            endcase
        end
        if (!supp_done) evt = '0;
    end

    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            out_r    <= RESET_OUT[WIDTH-1:0];
            dir_r    <= RESET_DIR[WIDTH-1:0];
            ie_r     <= '0;
            type_r   <= '0;
            pol_r    <= '0;
            status_r <= '0;
            supp_cnt <= '0;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
            irq_o    <= 1'b0;
        end else begin
            wb_ack_o <= access & mapped;
            wb_err_o <= access & ~mapped;
            wb_dat_o <= access ? rdata : '0;
            if (wr_en) begin
                case (req.adr)
                    OFS_OUT:  out_r  <= (out_r  & ~wmask) | wdat;
                    OFS_SET:  out_r  <= out_r | wdat;
                    OFS_CLR:  out_r  <= out_r & ~wdat;
                    OFS_DIR:  dir_r  <= (dir_r  & ~wmask) | wdat;
                    OFS_IE:   ie_r   <= (ie_r   & ~wmask) | wdat;
                    OFS_TYPE: type_r <= (type_r & ~wmask) | wdat;
                    OFS_POL:  pol_r  <= (pol_r  & ~wmask) | wdat;
                    default:  ;
                endcase
            end
            // A new event outranks a simultaneous clear.
            status_r <= (status_r & ~w1c) | evt;
            irq_o    <= |(status_r & ie_r);
            if (!supp_done) supp_cnt <= supp_cnt + CNT_W'(1);
        end
    end

    assign gpio_o     = out_r;
    assign gpio_dir_o = dir_r;
    assign wb_rty_o   = 1'b0;

    assign unused_ok = ^{wb_cti_i, wb_bte_i, req, bmask};

endmodule
